decode_stage: RTL

- Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Captures pc_f/instr_f in an IF/ID pipeline register with stall and flush control.
- Holds the 32x32 integer register file (writeback port from W stage) with write-through bypass, extracts instruction fields, generates the sign-extended immediate and flags unsupported opcodes.

---
 rtl/decode_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage of the RV32I pipeline: IF/ID pipeline register with
// stall/flush, 32-entry register file with write-through bypass, field
// extraction, immediate generation and unsupported-opcode detection.
module decode_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_f,
    input  logic [31:0]     instr_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            reg_write_w,
    input  logic [4:0]      rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] pc_d,
    output logic [31:0]     instr_d,
    output logic            valid_d,
    output logic [6:0]      opcode_d,
    output logic [4:0]      rd_d,
    output logic [2:0]      funct3_d,
    output logic [4:0]      rs1_addr_d,
    output logic [4:0]      rs2_addr_d,
    output logic [6:0]      funct7_d,
    output logic [XLEN-1:0] rs1_data_d,
    output logic [XLEN-1:0] rs2_data_d,
    output logic [XLEN-1:0] imm_d,
    output logic            illegal_d
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic [XLEN-1:0]   r_regs [0:31];

    logic              w_wr_en;
    logic              w_byp1;
    logic              w_byp2;
    logic signed [31:0] w_imm32;
    logic              w_legal;

    // IF/ID register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement or block ordering.
        if (reset) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (flush_d) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!stall_d) begin
            r_pc    <= pc_f;
            r_instr <= instr_f;
            r_valid <= 1'b1;
        end
    end

    assign w_wr_en = reg_write_w && (rd_w != 5'd0);

    // Register file write port; writeback ignores stall/flush, reset clears all.
    always_ff @(posedge clk) begin
        // NOTE: the file must read zero after reset, so every entry is cleared;
        // this rules out mapping it onto a RAM macro that cannot be reset.
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd_w] <= result_w;
        end
    end

    assign w_byp1 = w_wr_en && (rd_w == r_instr[19:15]);
    assign w_byp2 = w_wr_en && (rd_w == r_instr[24:20]);

    // x0 is hard-wired to zero ahead of the bypass check.
    assign rs1_data_d = (r_instr[19:15] == 5'd0) ? '0 :
                        w_byp1 ? result_w : r_regs[r_instr[19:15]];
    assign rs2_data_d = (r_instr[24:20] == 5'd0) ? '0 :
                        w_byp2 ? result_w : r_regs[r_instr[24:20]];

    // Immediate format and opcode legality, both selected by opcode.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would infer a latch.
        w_imm32 = '0;
        w_legal = 1'b0;
        case (r_instr[6:0])
            OP_I_ALU, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
                w_legal = 1'b1;
            end
            OP_STORE: begin
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
                w_legal = 1'b1;
            end
            OP_BRANCH: begin
                w_imm32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                           r_instr[30:25], r_instr[11:8], 1'b0};
                w_legal = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {r_instr[31:12], 12'b0};
                w_legal = 1'b1;
            end
            OP_JAL: begin
                w_imm32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                           r_instr[20], r_instr[30:21], 1'b0};
                w_legal = 1'b1;
            end
            OP_R, OP_FENCE: begin
                w_legal = 1'b1;
            end
            default: begin
                w_imm32 = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign pc_d       = r_pc;
    assign instr_d    = r_instr;
    assign valid_d    = r_valid;
    assign opcode_d   = r_instr[6:0];
    assign rd_d       = r_instr[11:7];
    assign funct3_d   = r_instr[14:12];
    assign rs1_addr_d = r_instr[19:15];
    assign rs2_addr_d = r_instr[24:20];
    assign funct7_d   = r_instr[31:25];
    assign imm_d      = XLEN'(w_imm32);
    assign illegal_d  = r_valid && !w_legal;

endmodule
